simplified_sha256: RTL and testbench

- Memory-mapped SHA-256 co-processor.
- On start, reads a NUM_OF_WORDS-word message from a shared single-port 32-bit word memory and pads it to two 512-bit blocks.
- Computes the standard SHA-256 digest, writes H0..H7 back to memory, then raises done.
- Sits beside the host/testbench memory and shares its read/write port.

---
 rtl/simplified_sha256.sv | 181 ++++++++++++++++++
 tb/tb_simplified_sha256.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/simplified_sha256.sv
// simplified_sha256: memory-mapped SHA-256 co-processor.
//   Fetches NUM_OF_WORDS message words from a shared single-port word memory,
//   pads them into two 512-bit blocks, hashes them and writes H0..H7 back.
// Ports:
//   clk            system clock (rising edge)
//   reset_n        synchronous reset, active HIGH (historical name)
//   start          level request, only looked at in IDLE
//   message_addr   word address of message word 0
//   output_addr    word address receiving H0 (H1..H7 follow)
//   mem_read_data  memory read data (valid one mem_clk edge after mem_addr)
//   done           result written; held until reset or next accepted start
//   mem_clk        memory clock, same as clk
//   mem_we         memory write enable
//   mem_addr       memory word address
//   mem_write_data memory write data
module simplified_sha256 #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  input  logic [31:0] mem_read_data,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] BLOCK   = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [5:0]  NW       = 6'(NUM_OF_WORDS);
  localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [2:0]  state;
  logic [5:0]  cnt;       // read index / round t / write index
  logic        blk;       // 0 = first padded block, 1 = second
  logic [15:0] msg_base, out_base;
  logic [31:0] mbuf [32]; // message + padding, both blocks
  logic [31:0] w    [16]; // w[0] is W[t]; window holds W[t..t+15]
  logic [31:0] h    [8];
  logic [31:0] a, b, c, d, e, f, g, hh;

  logic [31:0] big_s1, ch, big_s0, maj, t1, t2, w_next;

  assign mem_clk = clk;

  always_comb begin
    big_s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
    ch     = (e & f) ^ (~e & g);
    t1     = hh + big_s1 + ch + K[cnt] + w[0];
    big_s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
    maj    = (a & b) ^ (a & c) ^ (b & c);
    t2     = big_s0 + maj;
    // W[t+16] from the window; pushed in every round so w[0] is always W[t]
    w_next = w[0] + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[9]
           + (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10));
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state          <= IDLE;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      cnt            <= '0;
      blk            <= 1'b0;
      msg_base       <= '0;
      out_base       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done     <= 1'b0;
            msg_base <= message_addr;
            out_base <= output_addr;
            mem_addr <= message_addr;  // first read issued right away
            cnt      <= '0;
            blk      <= 1'b0;
            for (int i = 0; i < 8; i++) h[i] <= IV[i];
            for (int i = 0; i < 32; i++)
              if (i >= NUM_OF_WORDS)
                mbuf[i] <= (i == NUM_OF_WORDS) ? 32'h8000_0000 :
                           (i == 31)           ? LEN_BITS : 32'h0;
            state <= READ;
          end
        end
        READ: begin
          // data for the address issued two edges ago lands now
          if (cnt != 6'd0) mbuf[5'(cnt - 6'd1)] <= mem_read_data;
          if (cnt + 6'd1 < NW) mem_addr <= msg_base + 16'(cnt + 6'd1);
          if (cnt == NW) begin
            cnt   <= '0;
            state <= BLOCK;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        BLOCK: begin
          for (int i = 0; i < 16; i++) w[i] <= mbuf[{blk, 4'(i)}];
          a <= h[0]; b <= h[1]; c <= h[2]; d <= h[3];
          e <= h[4]; f <= h[5]; g <= h[6]; hh <= h[7];
          cnt   <= '0;
          state <= COMPUTE;
        end
        COMPUTE: begin
          a <= t1 + t2; b <= a; c <= b; d <= c;
          e <= d + t1;  f <= e; g <= f; hh <= g;
          for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
          w[15] <= w_next;
          if (cnt == 6'd63) begin
            // fold in the post-round-63 working variables directly
            h[0] <= h[0] + t1 + t2;
            h[1] <= h[1] + a;
            h[2] <= h[2] + b;
            h[3] <= h[3] + c;
            h[4] <= h[4] + d + t1;
            h[5] <= h[5] + e;
            h[6] <= h[6] + f;
            h[7] <= h[7] + g;
            cnt  <= '0;
            if (!blk) begin
              blk   <= 1'b1;
              state <= BLOCK;
            end else begin
              state <= WRITE;
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        WRITE: begin
          if (cnt < 6'd8) begin
            mem_we         <= 1'b1;
            mem_addr       <= out_base + 16'(cnt);
            mem_write_data <= h[cnt[2:0]];
            cnt            <= cnt + 6'd1;
          end else begin
            mem_we <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simplified_sha256.sv
// Randomized bench for simplified_sha256 against a plain SHA-256 reference.
module tb_simplified_sha256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] message_addr = '0;
  logic [15:0] output_addr = '0;
  logic [31:0] mem_read_data;
  logic        done, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;

  simplified_sha256 #(.NUM_OF_WORDS(20)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .message_addr(message_addr), .output_addr(output_addr),
    .mem_read_data(mem_read_data), .done(done), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  // shared memory; bench loads it through its own port while the DUT is idle
  logic        tb_we = 1'b0;
  logic [15:0] tb_addr = '0;
  logic [31:0] tb_data = '0;
  logic [31:0] mem [65536];

  always @(posedge mem_clk) begin
    if (mem_we)     mem[mem_addr] <= mem_write_data;
    else if (tb_we) mem[tb_addr]  <= tb_data;
    mem_read_data <= mem[mem_addr];
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  localparam logic [31:0] KR [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVR [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [31:0] msg  [20];
  logic [31:0] blkw [16];
  logic [31:0] hs   [8];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // one FIPS 180-4 compression of blkw into hs
  task automatic compress();
    logic [31:0] wv [64];
    logic [31:0] v [8];
    logic [31:0] x1, x2;
    for (int t = 0; t < 64; t++)
      if (t < 16) wv[t] = blkw[t];
      else wv[t] = (rotr(wv[t-2], 17) ^ rotr(wv[t-2], 19) ^ (wv[t-2] >> 10)) + wv[t-7]
                 + (rotr(wv[t-15], 7) ^ rotr(wv[t-15], 18) ^ (wv[t-15] >> 3)) + wv[t-16];
    for (int i = 0; i < 8; i++) v[i] = hs[i];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KR[t] + wv[t];
      x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) hs[i] = hs[i] + v[i];
  endtask

  // build msg from seed and compute its digest into hs
  task automatic ref_hash(input logic [31:0] seed);
    logic [31:0] pad [32];
    msg[0] = seed;
    for (int m = 1; m < 19; m++) msg[m] = {msg[m-1][30:0], msg[m-1][31]};
    msg[19] = 32'h0;
    for (int i = 0; i < 32; i++) pad[i] = (i < 20) ? msg[i] : 32'h0;
    pad[20] = 32'h8000_0000;
    pad[31] = 32'd640;
    for (int i = 0; i < 8; i++) hs[i] = IVR[i];
    for (int bk = 0; bk < 2; bk++) begin
      for (int i = 0; i < 16; i++) blkw[i] = pad[16*bk + i];
      compress();
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic poke(input logic [15:0] adr, input logic [31:0] dat);
    tb_addr = adr; tb_data = dat; tb_we = 1'b1;
    @(posedge clk); @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] seed, input logic [15:0] ma, input logic [15:0] oa);
    ref_hash(seed);
    for (int i = 0; i < 20; i++) poke(ma + 16'(i), msg[i]);
    for (int i = 0; i < 8; i++) poke(oa + 16'(i), 32'hDEAD_0000 | i);
    poke(oa - 16'd1, 32'hA5A5_0001);
    poke(oa + 16'd8, 32'hA5A5_0002);
    message_addr = ma;
    output_addr  = oa;
  endtask

  logic [15:0] seq [64];
  int          nseq;

  // start held for 'hold' edges; watch until done or budget expires
  task automatic do_run(input int hold, input int budget,
                        output int cyc, output int nwr, output logic got_done);
    logic saw_we = 1'b0;
    start = 1'b1; cyc = 0; nwr = 0; nseq = 0; got_done = 1'b0;
    while (cyc < budget && !got_done) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (cyc == 1) chk("done_drop", {31'b0, done}, 32'd0);
      if (mem_we) begin
        nwr++; saw_we = 1'b1;
      end else if (!saw_we && nseq < 64 && (nseq == 0 || mem_addr != seq[nseq-1])) begin
        seq[nseq] = mem_addr; nseq++;
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic full_run(input string tag, input logic [31:0] seed,
                          input logic [15:0] ma, input logic [15:0] oa, input int hold);
    int cyc, nwr, bad;
    logic gd;
    load(seed, ma, oa);
    do_run(hold, 220, cyc, nwr, gd);
    chk({tag, "_done"}, {31'b0, gd}, 32'd1);
    chk({tag, "_lat200"}, (cyc <= 200) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, "_nwr"}, 32'(nwr), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_H%0d", tag, i), mem[oa + 16'(i)], hs[i]);
    chk({tag, "_below"}, mem[oa - 16'd1], 32'hA5A5_0001);
    chk({tag, "_above"}, mem[oa + 16'd8], 32'hA5A5_0002);
    bad = 0;
    for (int i = 0; i < 20; i++) if (mem[ma + 16'(i)] !== msg[i]) bad++;
    chk({tag, "_src"}, 32'(bad), 32'd0);
    chk({tag, "_rdlen"}, 32'(nseq), 32'd20);
    bad = 0;
    for (int i = 0; i < 20 && i < nseq; i++) if (seq[i] != ma + 16'(i)) bad++;
    chk({tag, "_rdord"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int cyc, nwr;
    logic gd;
    logic [15:0] ma, oa;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", {16'b0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    reset_n = 1'b0;

    // model sanity: SHA-256("abc")
    for (int i = 0; i < 8; i++) hs[i] = IVR[i];
    for (int i = 0; i < 16; i++) blkw[i] = 32'h0;
    blkw[0] = 32'h6162_6380; blkw[15] = 32'd24;
    compress();
    chk("abc0", hs[0], 32'hba7816bf); chk("abc7", hs[7], 32'hf20015ad);

    full_run("dflt", 32'h0123_4567, 16'd0, 16'd1000, 2);
    full_run("ones", 32'hFFFF_FFFF, 16'd0, 16'd500, 2);

    // reset in the middle of block-0 rounds
    load(32'hCAFE_F00D, 16'd2000, 16'd3000);
    do_run(2, 60, cyc, nwr, gd);
    chk("mid_notdone", {31'b0, gd}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_we", {31'b0, mem_we}, 32'd0);
    reset_n = 1'b0;
    nwr = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); @(negedge clk);
      if (mem_we) nwr++;
    end
    chk("abort_nowr", 32'(nwr), 32'd0);
    chk("abort_out", mem[16'd3000], 32'hDEAD_0000);
    full_run("after_rst", 32'hCAFE_F00D, 16'd2000, 16'd3000, 2);

    // back-to-back into the same output window with a new message
    full_run("b2b", 32'h1357_9BDF, 16'd2000, 16'd3000, 1);

    full_run("hold10", 32'h0BAD_BEEF, 16'd4000, 16'd4100, 10);

    // 16-bit address wrap for message and output
    full_run("wrap_msg", $urandom, 16'hFFF0, 16'h8000, 2);
    full_run("wrap_out", $urandom, 16'h4000, 16'hFFFC, 2);

    for (int r = 0; r < 3; r++) begin
      ma = 16'($urandom_range(16, 30000));
      oa = ma + 16'd64 + 16'($urandom_range(0, 30000));
      full_run($sformatf("rnd%0d", r), $urandom, ma, oa, 1 + $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
